// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video subsystem types, limits and helpers
package video_pkg;

  localparam int SD_MAX_NBUF = 4;
  localparam int SD_MIN_NBUF = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef logic [clog2(SD_MAX_NBUF)-1:0] bank_ptr_t;

  // Explicit wrap so non-power-of-two bank counts (e.g. 3) go 2 -> 0.
  function automatic bank_ptr_t next_bank(input bank_ptr_t b, input int nbuf);
    return (int'(b) >= nbuf - 1) ? '0 : bank_ptr_t'(b + 1'b1);
  endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port line store with registered read port
module line_ram
  import video_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1536,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk24,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk24) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/scan_doubler.sv
// rtl/scan_doubler.sv - ring-of-banks line buffer replaying each line once or twice
module scan_doubler
  import video_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                LINE_LEN = 768,
  parameter int                NBUF     = 2,
  parameter logic [DATA_W-1:0] BLANK    = '0
) (
  input  logic              clk24,
  input  logic              reset,
  input  logic              ce_wr,
  input  logic              wr_line_start,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ce_rd,
  input  logic              rd_line_start,
  input  logic              double_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              overrun,
  output logic              underrun,
  output logic              truncated
);

  localparam int LW = clog2(LINE_LEN + 1);
  localparam int BW = clog2(NBUF);
  localparam int CW = BW + 1;
  localparam int AW = clog2(NBUF * LINE_LEN);
  localparam logic [LW-1:0] LEN_MAX = LW'(LINE_LEN);

  logic [LW-1:0]     wa, ra;
  logic [LW-1:0]     len [NBUF];
  logic [BW-1:0]     wb, rb, wb_next;
  logic [CW-1:0]     cnt, cnt_avail;
  logic              rep, primed;
  logic              commit_ok, we, re, take, repl, adv, urun;
  logic [1:0]        need;
  logic [AW-1:0]     waddr, raddr;
  logic [DATA_W-1:0] ram_q;

  // Until the first line is taken, cnt counts bank rb itself; afterwards it
  // counts only lines queued behind the bank being displayed.
  always_comb begin
    commit_ok = wr_line_start && (wa != '0) && (cnt < CW'(NBUF - 1));
    wb_next   = commit_ok ? BW'(next_bank(bank_ptr_t'(wb), NBUF)) : wb;
    we        = ce_wr && (wr_line_start || (wa < LEN_MAX));
    waddr     = AW'(wb_next) * AW'(LINE_LEN) + (wr_line_start ? '0 : AW'(wa));
    cnt_avail = cnt + CW'(commit_ok);
    re        = ce_rd && !rd_line_start && primed && (ra < len[rb]);
    raddr     = AW'(rb) * AW'(LINE_LEN) + AW'(ra);
    need      = double_en ? 2'd2 : 2'd1;
    take      = 1'b0;
    repl      = 1'b0;
    adv       = 1'b0;
    urun      = 1'b0;
    if (rd_line_start) begin
      if (!primed)                     take = (cnt_avail != '0);
      else if ({1'b0, rep} + 2'd1 < need) repl = 1'b1;
      else if (cnt_avail != '0)        adv  = 1'b1;
      else                             urun = 1'b1;
    end
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      wa        <= '0;
      wb        <= '0;
      ra        <= '0;
      rb        <= '0;
      cnt       <= '0;
      rep       <= 1'b0;
      primed    <= 1'b0;
      rd_valid  <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      truncated <= 1'b0;
      for (int i = 0; i < NBUF; i++) len[i] <= '0;
    end else begin
      overrun  <= wr_line_start && (wa != '0) && !commit_ok;
      underrun <= urun;
      cnt      <= cnt_avail - CW'(take || adv);
      if (wr_line_start) begin
        wa <= ce_wr ? LW'(1) : '0;
        if (commit_ok) begin
          len[wb] <= wa;
          wb      <= wb_next;
        end
      end else if (ce_wr) begin
        if (wa < LEN_MAX) wa <= wa + 1'b1;
        else              truncated <= 1'b1;
      end
      if (rd_line_start) begin
        ra <= '0;
        if (take || adv) rep <= 1'b0;
        if (repl)        rep <= 1'b1;
        if (take)        primed <= 1'b1;
        if (adv)         rb <= BW'(next_bank(bank_ptr_t'(rb), NBUF));
      end else if (ce_rd) begin
        rd_valid <= re;
        if (ra < LEN_MAX) ra <= ra + 1'b1;
      end
    end
  end

  line_ram #(
    .DATA_W(DATA_W),
    .DEPTH (NBUF * LINE_LEN),
    .AW    (AW)
  ) u_ram (
    .clk24(clk24),
    .we   (we),
    .waddr(waddr),
    .wdata(wr_data),
    .re   (re),
    .raddr(raddr),
    .q    (ram_q)
  );

  assign rd_data = rd_valid ? ram_q : BLANK;

endmodule

// File: tb/tb_scan_doubler.sv
// tb/tb_scan_doubler.sv - directed bench for scan_doubler with 2-bank and 3-bank instances
module tb_scan_doubler;

  logic       clk24 = 1'b0;
  logic       reset, ce_wr, wr_line_start, ce_rd, rd_line_start, double_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data2, rd_data3;
  logic       rd_valid2, rd_valid3, ov2, ov3, un2, un3, tr2, tr3;

  int vectors = 0;
  int miscompares = 0;
  int ov2_n = 0, un2_n = 0, ov3_n = 0, un3_n = 0;

  logic [7:0] cd2 [0:1023];
  logic [7:0] cd3 [0:1023];
  logic       cv2 [0:1023];
  logic       cv3 [0:1023];

  always #5 clk24 = ~clk24;

  scan_doubler #(.DATA_W(8), .LINE_LEN(768), .NBUF(2), .BLANK(8'h00)) dut2 (
    .clk24(clk24), .reset(reset), .ce_wr(ce_wr), .wr_line_start(wr_line_start),
    .wr_data(wr_data), .ce_rd(ce_rd), .rd_line_start(rd_line_start),
    .double_en(double_en), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .overrun(ov2), .underrun(un2), .truncated(tr2));

  scan_doubler #(.DATA_W(8), .LINE_LEN(768), .NBUF(3), .BLANK(8'h00)) dut3 (
    .clk24(clk24), .reset(reset), .ce_wr(ce_wr), .wr_line_start(wr_line_start),
    .wr_data(wr_data), .ce_rd(ce_rd), .rd_line_start(rd_line_start),
    .double_en(double_en), .rd_data(rd_data3), .rd_valid(rd_valid3),
    .overrun(ov3), .underrun(un3), .truncated(tr3));

  always @(negedge clk24) begin
    if (ov2) ov2_n++;
    if (un2) un2_n++;
    if (ov3) ov3_n++;
    if (un3) un3_n++;
  end

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ce_wr = 1'b0; wr_line_start = 1'b0; ce_rd = 1'b0;
    rd_line_start = 1'b0; wr_data = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_px(input int n, input int s, input int k);
    for (int i = 0; i < n; i++) begin
      ce_wr = 1'b1;
      wr_data = 8'(s + i * k);
      tick();
    end
    ce_wr = 1'b0;
  endtask

  task automatic wr_start();
    wr_line_start = 1'b1;
    tick();
    wr_line_start = 1'b0;
  endtask

  task automatic rd_start();
    rd_line_start = 1'b1;
    tick();
    rd_line_start = 1'b0;
  endtask

  task automatic read_px(input int n);
    for (int i = 0; i < n; i++) begin
      ce_rd = 1'b1;
      tick();
      cd2[i] = rd_data2; cv2[i] = rd_valid2;
      cd3[i] = rd_data3; cv3[i] = rd_valid3;
    end
    ce_rd = 1'b0;
  endtask

  task automatic test_reset();
    int u;
    double_en = 1'b0;
    do_reset();
    u = un2_n;
    vectors++;
    if ({rd_data2, rd_valid2, ov2, un2, tr2} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs_nbuf2 got %h/%b%b%b%b want 00/0000", rd_data2, rd_valid2, ov2, un2, tr2);
    end
    vectors++;
    if ({rd_data3, rd_valid3, ov3, un3, tr3} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs_nbuf3 got %h/%b%b%b%b want 00/0000", rd_data3, rd_valid3, ov3, un3, tr3);
    end
    rd_start();
    read_px(4);
    tick();
    vectors++;
    if (un2_n - u != 0 || cd2[3] !== 8'h00 || cv2[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL precommit_read got underruns=%0d px=%h/%b want 0 and 00/0", un2_n - u, cd2[3], cv2[3]);
    end
  endtask

  task automatic test_ramp_double();
    int bad, o, u;
    double_en = 1'b1;
    do_reset();
    o = ov2_n; u = un2_n;
    write_px(768, 0, 1);
    wr_start();
    for (int ln = 0; ln < 2; ln++) begin
      rd_start();
      read_px(768);
      bad = -1;
      for (int i = 0; i < 768; i++)
        if (bad < 0 && (cd2[i] !== 8'(i) || cv2[i] !== 1'b1)) bad = i;
      vectors++;
      if (bad >= 0) begin
        miscompares++;
        $display("FAIL ramp_line%0d pixel %0d got %h/%b want %h/1", ln, bad, cd2[bad], cv2[bad], 8'(bad));
      end
    end
    tick();
    vectors++;
    if (ov2_n - o != 0 || un2_n - u != 0) begin
      miscompares++;
      $display("FAIL ramp_pulses got ov=%0d un=%0d want 0 0", ov2_n - o, un2_n - u);
    end
  endtask

  task automatic test_short_line();
    int bad;
    double_en = 1'b0;
    do_reset();
    write_px(100, 7, 3);
    wr_start();
    rd_start();
    read_px(50);
    tick(); tick(); tick();
    vectors++;
    if (rd_data2 !== 8'(7 + 49 * 3) || rd_valid2 !== 1'b1) begin
      miscompares++;
      $display("FAIL short_hold got %h/%b want %h/1", rd_data2, rd_valid2, 8'(7 + 49 * 3));
    end
    read_px(718);
    bad = -1;
    for (int i = 0; i < 718; i++) begin
      if (i + 50 < 100) begin
        if (bad < 0 && (cd2[i] !== 8'(7 + (i + 50) * 3) || cv2[i] !== 1'b1)) bad = i + 50;
      end else begin
        if (bad < 0 && (cd2[i] !== 8'h00 || cv2[i] !== 1'b0)) bad = i + 50;
      end
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL short_line pixel %0d got %h/%b", bad, cd2[bad - 50], cv2[bad - 50]);
    end
  endtask

  task automatic test_overrun();
    int bad, o2, o3, u2, u3;
    double_en = 1'b0;
    do_reset();
    o2 = ov2_n; o3 = ov3_n; u2 = un2_n; u3 = un3_n;
    write_px(10, 40, 1);
    wr_start();
    write_px(10, 200, 1);
    wr_start();
    tick();
    vectors++;
    if (ov2_n - o2 != 1) begin
      miscompares++;
      $display("FAIL overrun_nbuf2 got %0d pulses want 1", ov2_n - o2);
    end
    vectors++;
    if (ov3_n - o3 != 0) begin
      miscompares++;
      $display("FAIL overrun_nbuf3 got %0d pulses want 0", ov3_n - o3);
    end
    rd_start();
    read_px(10);
    bad = -1;
    for (int i = 0; i < 10; i++)
      if (bad < 0 && (cd2[i] !== 8'(40 + i) || cv2[i] !== 1'b1)) bad = i;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL overrun_first_line pixel %0d got %h/%b want %h/1", bad, cd2[bad], cv2[bad], 8'(40 + bad));
    end
    rd_start();
    read_px(10);
    tick();
    vectors++;
    if (un2_n - u2 != 1 || un3_n - u3 != 0) begin
      miscompares++;
      $display("FAIL overrun_depth got un2=%0d un3=%0d want 1 0", un2_n - u2, un3_n - u3);
    end
    bad = -1;
    for (int i = 0; i < 10; i++)
      if (bad < 0 && (cd3[i] !== 8'(200 + i) || cv3[i] !== 1'b1 || cd2[i] !== 8'(40 + i))) bad = i;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL overrun_second_read pixel %0d got %h %h want %h %h", bad, cd2[bad], cd3[bad], 8'(40 + bad), 8'(200 + bad));
    end
  endtask

  task automatic test_underrun();
    int bad, u;
    double_en = 1'b0;
    do_reset();
    u = un2_n;
    rd_start();
    write_px(20, 90, 5);
    wr_start();
    rd_start();
    read_px(20);
    tick();
    vectors++;
    if (un2_n - u != 0) begin
      miscompares++;
      $display("FAIL underrun_early got %0d pulses want 0", un2_n - u);
    end
    rd_start();
    read_px(20);
    tick();
    vectors++;
    if (un2_n - u != 1) begin
      miscompares++;
      $display("FAIL underrun_third got %0d pulses want 1", un2_n - u);
    end
    bad = -1;
    for (int i = 0; i < 20; i++)
      if (bad < 0 && (cd2[i] !== 8'(90 + i * 5) || cv2[i] !== 1'b1)) bad = i;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL underrun_replay pixel %0d got %h/%b want %h/1", bad, cd2[bad], cv2[bad], 8'(90 + bad * 5));
    end
  endtask

  task automatic test_back_to_back();
    int bad, o2, o3, u2, u3;
    logic [7:0] exp_d;
    logic       exp_v;
    double_en = 1'b0;
    do_reset();
    o2 = ov2_n; o3 = ov3_n; u2 = un2_n; u3 = un3_n;
    for (int k = 0; k <= 10; k++) begin
      wr_line_start = 1'b1;
      rd_line_start = 1'b1;
      tick();
      wr_line_start = 1'b0;
      rd_line_start = 1'b0;
      bad = -1;
      for (int i = 0; i < 8; i++) begin
        ce_wr = 1'b1; wr_data = 8'(k * 16 + i); ce_rd = 1'b1;
        tick();
        exp_d = (k == 0) ? 8'h00 : 8'((k - 1) * 16 + i);
        exp_v = (k != 0);
        if (bad < 0 && (rd_data3 !== exp_d || rd_valid3 !== exp_v)) begin
          bad = i;
          $display("FAIL b2b_line%0d pixel %0d got %h/%b want %h/%b", k - 1, i, rd_data3, rd_valid3, exp_d, exp_v);
        end
      end
      ce_wr = 1'b0; ce_rd = 1'b0;
      vectors++;
      if (bad >= 0) miscompares++;
    end
    tick();
    vectors++;
    if (ov3_n - o3 != 0 || un3_n - u3 != 0 || ov2_n - o2 != 0 || un2_n - u2 != 0) begin
      miscompares++;
      $display("FAIL b2b_pulses got ov3=%0d un3=%0d ov2=%0d un2=%0d want all 0", ov3_n - o3, un3_n - u3, ov2_n - o2, un2_n - u2);
    end
  endtask

  task automatic test_truncate_reset();
    int bad, u;
    double_en = 1'b0;
    do_reset();
    write_px(770, 0, 1);
    vectors++;
    if (tr2 !== 1'b1) begin
      miscompares++;
      $display("FAIL truncated_set got %b want 1", tr2);
    end
    wr_start();
    rd_start();
    read_px(770);
    bad = -1;
    for (int i = 0; i < 770; i++) begin
      if (i < 768) begin
        if (bad < 0 && (cd2[i] !== 8'(i) || cv2[i] !== 1'b1)) bad = i;
      end else begin
        if (bad < 0 && (cd2[i] !== 8'h00 || cv2[i] !== 1'b0)) bad = i;
      end
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL truncated_line pixel %0d got %h/%b", bad, cd2[bad], cv2[bad]);
    end
    vectors++;
    if (tr2 !== 1'b1) begin
      miscompares++;
      $display("FAIL truncated_sticky got %b want 1", tr2);
    end
    rd_start();
    read_px(10);
    ce_wr = 1'b1; wr_data = 8'hAA; ce_rd = 1'b1; reset = 1'b1;
    tick();
    vectors++;
    if ({rd_data2, rd_valid2, ov2, un2, tr2} !== 12'h000) begin
      miscompares++;
      $display("FAIL midline_reset got %h/%b%b%b%b want 00/0000", rd_data2, rd_valid2, ov2, un2, tr2);
    end
    reset = 1'b0; ce_wr = 1'b0; ce_rd = 1'b0;
    u = un2_n;
    rd_start();
    read_px(8);
    tick();
    bad = -1;
    for (int i = 0; i < 8; i++)
      if (bad < 0 && (cd2[i] !== 8'h00 || cv2[i] !== 1'b0)) bad = i;
    vectors++;
    if (bad >= 0 || un2_n - u != 0) begin
      miscompares++;
      $display("FAIL post_reset_line got bad_px=%0d underruns=%0d want -1 0", bad, un2_n - u);
    end
  endtask

  initial begin
    reset = 1'b1; ce_wr = 1'b0; wr_line_start = 1'b0; wr_data = 8'h00;
    ce_rd = 1'b0; rd_line_start = 1'b0; double_en = 1'b0;
    test_reset();
    test_ramp_double();
    test_short_line();
    test_overrun();
    test_underrun();
    test_back_to_back();
    test_truncate_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
